// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizer, clock glitch filter, 11-bit frame FSM.
// Optional frame watchdog built only when PS2_RX_WATCHDOG_EN is defined.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       error
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] taps;
    logic                  filt;
    logic                  sample;
    logic [0:0]            state;
    logic [3:0]            cnt;
    logic [8:0]            sr;
    logic [9:0]            frame_next;
    logic                  good;
    logic                  timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered level only moves once every tap agrees; mixed taps hold it.
    always_ff @(posedge clk) begin
        if (reset) begin
            taps <= '1;
            filt <= 1'b1;
        end else begin
            taps <= {taps[FILTER_LEN-2:0], clk_s2};
            if (taps == '0)
                filt <= 1'b0;
            else if (&taps)
                filt <= 1'b1;
        end
    end

    assign sample     = filt & (taps == '0);
    assign frame_next = {dat_s2, sr};
    // frame_next = {stop, parity, d7..d0} on the closing event
    assign good       = (^frame_next[8:0]) & frame_next[9];

`ifdef PS2_RX_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo;

    always_ff @(posedge clk) begin
        if (reset || state != RECV || sample)
            tmo <= '0;
        else
            tmo <= tmo + TW'(1);
    end

    assign timeout = (state == RECV) && !sample && (tmo == TW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            sr    <= '0;
            data  <= 8'h00;
            valid <= 1'b0;
            error <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample && !dat_s2) begin
                        state <= RECV;
                        cnt   <= 4'd1;
                    end
                end
                default: begin
                    if (sample) begin
                        sr <= frame_next[9:1];
                        if (cnt == 4'd10) begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                            if (good) begin
                                data  <= frame_next[7:0];
                                valid <= 1'b1;
                            end else begin
                                error <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else if (timeout) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                        error <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// Randomized self-checking bench for ps2_rx against a frame-level reference model.
// Exercises the watchdog path when PS2_RX_WATCHDOG_EN is defined.
module tb_ps2_rx;
    localparam int FL  = 8;
    localparam int TMO = 5000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic       valid, error;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data(data), .valid(valid), .error(error)
    );

    always #20 clk = ~clk;

    int     n_cmp = 0, n_bad = 0, n_both = 0;
    longint cyc = 0;
    longint last_fall = 0;

    int         ev_kind[$];
    logic [7:0] ev_data[$];
    longint     ev_cyc[$];
    int         exp_kind[$];
    logic [7:0] exp_data_q[$];
    logic [7:0] exp_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor records every pulse, including any during reset.
    always @(negedge clk) begin
        if (valid === 1'b1 && error === 1'b1) n_both++;
        if (valid === 1'b1) begin ev_kind.push_back(1); ev_data.push_back(data); ev_cyc.push_back(cyc); end
        if (error === 1'b1) begin ev_kind.push_back(2); ev_data.push_back(data); ev_cyc.push_back(cyc); end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic p, input logic s);
        return {s, p, b, 1'b0};
    endfunction

    // Reference: a frame is good when data+parity hold an odd count of ones and stop is 1.
    task automatic expect_frame(input logic [7:0] b, input logic p, input logic s);
        if ((($countones(b) + int'(p)) % 2 == 1) && s) begin
            exp_data = b;
            exp_kind.push_back(1);
        end else begin
            exp_kind.push_back(2);
        end
        exp_data_q.push_back(exp_data);
    endtask

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi, input int half);
        for (int i = lo; i <= hi; i++) begin
            ps2_data = f[i];
            repeat (half) @(posedge clk);
            ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (half) @(posedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s, input int half);
        send_bits(mkframe(b, p, s), 0, 10, half);
        ps2_data = 1'b1;
        expect_frame(b, p, s);
    endtask

    task automatic check_events(input string tag);
        int n;
        repeat (4) @(posedge clk);
        chk($sformatf("%s_count", tag), ev_kind.size(), exp_kind.size());
        n = (ev_kind.size() < exp_kind.size()) ? ev_kind.size() : exp_kind.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_kind%0d", tag, i), ev_kind[i], exp_kind[i]);
            chk($sformatf("%s_data%0d", tag, i), ev_data[i], exp_data_q[i]);
        end
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
        exp_kind.delete(); exp_data_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       p, s;
        int         half;
        longint     f4;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // 12.5 kHz PS/2 clock against 25 MHz clk: 1000-cycle half period
        send_frame(8'h1C, 1'b0, 1'b1, 1000);
        check_events("f1c");

        send_frame(8'hE0, 1'b0, 1'b1, 40);
        send_frame(8'h75, 1'b0, 1'b1, 40);
        check_events("b2b");

        send_frame(8'hF0, 1'b0, 1'b1, 40);
        check_events("badpar");

        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(posedge clk);
        check_events("glitch");
        send_frame(8'h29, 1'b0, 1'b1, 40);
        check_events("f29");

`ifdef PS2_RX_WATCHDOG_EN
        send_bits(mkframe(8'h33, 1'b1, 1'b1), 0, 3, 40);
        f4 = last_fall;
        ps2_data = 1'b1;
        repeat (TMO + 100) @(posedge clk);
        chk("wdog_count", ev_kind.size(), 1);
        if (ev_kind.size() == 1) begin
            chk("wdog_kind", ev_kind[0], 2);
            chk("wdog_data", ev_data[0], exp_data);
            chk("wdog_lat", (ev_cyc[0] >= f4 + TMO && ev_cyc[0] <= f4 + TMO + FL + 8) ? 1 : 0, 1);
        end
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
        send_frame(8'h5A, 1'b1, 1'b1, 40);
        check_events("f5a");
`else
        // Without the watchdog a stalled frame resumes where it stopped.
        send_bits(mkframe(8'h33, 1'b1, 1'b1), 0, 3, 40);
        f4 = last_fall;
        repeat (TMO + 100) @(posedge clk);
        check_events("stall");
        send_bits(mkframe(8'h33, 1'b1, 1'b1), 4, 10, 40);
        ps2_data = 1'b1;
        expect_frame(8'h33, 1'b1, 1'b1);
        check_events("resume");
        chk("stall_gap", (cyc - f4 > TMO) ? 1 : 0, 1);
`endif

        send_bits(mkframe(8'hA5, 1'b1, 1'b1), 0, 5, 40);
        reset = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        reset = 1'b0;
        exp_data = 8'h00;
        repeat (20) @(posedge clk);
        check_events("midrst");
        send_frame(8'h16, 1'b0, 1'b1, 40);
        check_events("f16");

        for (int i = 0; i < 14; i++) begin
            b    = 8'($urandom);
            p    = 1'($urandom);
            s    = ($urandom_range(0, 7) != 0);
            half = $urandom_range(20, 60);
            send_frame(b, p, s, half);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 200)) @(posedge clk);
            check_events($sformatf("rnd%0d", i));
        end

        chk("excl", n_both, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive identical synchronized ps2_clk samples needed to change the filtered clock level; legal range 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: number of clk cycles without a filtered falling edge, while a frame is open, that aborts the frame; legal range 16..2^20.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 data  output  8  last correctly received scan byte (e.g. 0xE0, 0xF0 or a key code).
REQ-008 valid  output  1  single-cycle pulse: data was updated with a new good byte.
REQ-009 error  output  1  single-cycle pulse: a frame was rejected or aborted.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 Filter: a FILTER_LEN-deep shift register of synchronized ps2_clk; filtered clock goes 0 when all taps are 0, goes 1 when all taps are 1, otherwise holds its value.
REQ-012 A sample event SHALL be the single cycle in which the filtered clock changes from 1 to 0; synchronized ps2_data is captured in that cycle.
REQ-013 Frame format: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1); 11 sample events in total.
REQ-014 FSM states: IDLE and RECV; RECV holds a 4-bit bit counter 0..10.
REQ-015 IDLE: a sample event with data=0 -> RECV, counter=1; a sample event with data=1 SHALL be ignored (stay in IDLE, no error).
REQ-016 RECV: each sample event shifts the captured bit into the frame register and increments the counter; the event with counter=10 closes the frame and returns the FSM to IDLE.
REQ-017 Frame check: the frame is good if the data bits plus the parity bit contain an odd number of 1s and the stop bit is 1.
REQ-018 Good frame: in the cycle after the closing event, data SHALL show the byte and valid=1 for exactly one cycle.
REQ-019 Bad frame: in the cycle after the closing event, error=1 for exactly one cycle and data is unchanged.
REQ-020 valid and error SHALL never be asserted in the same cycle; both are 0 in every other cycle.
REQ-021 Back-to-back frames with no idle gap SHALL be received with no byte lost; the FSM is back in IDLE before the next start edge can occur.
REQ-022 Transitions of ps2_data while the filtered clock is not falling SHALL have no effect.

Reset
REQ-023 reset=1 SHALL set: data=0x00, valid=0, error=0, FSM=IDLE, counter=0, all filter taps and the filtered clock=1, synchronizer flops=1, timeout counter=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no valid or error pulse; reception restarts at the next start bit after reset is released.

Configuration
REQ-025 Macro PS2_RX_WATCHDOG_EN defined: in RECV, the timeout counter increments every cycle and clears on each sample event; when it reaches TIMEOUT_CYCLES the FSM SHALL go to IDLE and pulse error for one cycle, and data is unchanged.
REQ-026 Macro PS2_RX_WATCHDOG_EN undefined: the timeout counter and its logic are not built; a partial frame stays open until it receives its remaining sample events; the TIMEOUT_CYCLES parameter is ignored.

Verification
REQ-027 Frame 0x1C, parity=0, stop=1 at a 12.5 kHz PS/2 clock with clk at 25 MHz -> one valid pulse, data=0x1C, error stays 0.
REQ-028 Frames 0xE0 (parity 0) then 0x75 (parity 0), back to back -> two valid pulses, data=0xE0 then data=0x75.
REQ-029 Frame 0xF0 sent with parity=0 (wrong) -> one error pulse, no valid pulse, data keeps its previous value.
REQ-030 3-cycle low glitch on ps2_clk while idle, with FILTER_LEN=8 -> no state change; a following 0x29 frame is received correctly.
REQ-031 With PS2_RX_WATCHDOG_EN: send 4 bits, then stop the clock -> error pulse TIMEOUT_CYCLES cycles after the 4th sample event; a next frame 0x5A (parity 1) gives valid with data=0x5A.
REQ-032 Reset pulsed after 6 bits of a frame, then a full 0x16 frame -> no pulse during the reset, then valid with data=0x16.
